// File: rtl/hyperbus_arb_pkg.sv
// Shared types for the HyperBus transaction arbiter: FSM state encoding and
// the registered command record handed to the PHY.
package hyperbus_arb_pkg;

  localparam int HYPER_NR_CS   = 2;
  localparam int HYPER_BURST_W = 12;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_READ  = 2'd2,
    ARB_WRITE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [31:0]              address;
    logic [HYPER_NR_CS-1:0]   cs;
    logic                     write;
    logic [HYPER_BURST_W-1:0] burst;
    logic                     burst_type;
    logic                     address_space;
  } hyper_cmd_t;

endpackage

// File: rtl/hyperbus_rr_select.sv
// Rotating-priority encoder: first valid requester at or after the rr pointer
// (wrapping) wins; returns a one-hot grant and its index.
module hyperbus_rr_select #(
  parameter int NR_REQ = 2,
  parameter int IDX_W  = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0] valid,
  input  logic [IDX_W-1:0]  rr,
  output logic [NR_REQ-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  // Scan from the lowest priority down so the highest-priority hit is written last.
  always_comb begin
    int pos;
    grant = '0;
    idx   = '0;
    pos   = 0;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      pos = int'(rr) + k;
      if (pos >= NR_REQ) begin
        pos = pos - NR_REQ;
      end else begin
        pos = pos;
      end
      if (valid[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end else begin
        idx = idx;
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Shares one HyperBus PHY transaction channel between NR_REQ requesters and
// steers tx/rx/b handshakes to the owner until its transaction completes.
module hyperbus_trans_arbiter
  import hyperbus_arb_pkg::*;
#(
  parameter int NR_REQ      = 2,
  parameter int NR_CS       = HYPER_NR_CS,
  parameter int BURST_WIDTH = HYPER_BURST_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NR_REQ-1:0]             req_trans_valid_i,
  output logic [NR_REQ-1:0]             req_trans_ready_o,
  input  logic [NR_REQ*32-1:0]          req_trans_address_i,
  input  logic [NR_REQ*NR_CS-1:0]       req_trans_cs_i,
  input  logic [NR_REQ-1:0]             req_trans_write_i,
  input  logic [NR_REQ*BURST_WIDTH-1:0] req_trans_burst_i,
  input  logic [NR_REQ-1:0]             req_trans_burst_type_i,
  input  logic [NR_REQ-1:0]             req_trans_address_space_i,
  output logic                          trans_valid_o,
  input  logic                          trans_ready_i,
  output logic [31:0]                   trans_address_o,
  output logic [NR_CS-1:0]              trans_cs_o,
  output logic                          trans_write_o,
  output logic [BURST_WIDTH-1:0]        trans_burst_o,
  output logic                          trans_burst_type_o,
  output logic                          trans_address_space_o,
  input  logic [NR_REQ-1:0]             req_tx_valid_i,
  output logic [NR_REQ-1:0]             req_tx_ready_o,
  input  logic [NR_REQ*16-1:0]          req_tx_data_i,
  input  logic [NR_REQ*2-1:0]           req_tx_strb_i,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [15:0]                   tx_data_o,
  output logic [1:0]                    tx_strb_o,
  input  logic                          rx_valid_i,
  input  logic                          rx_last_i,
  output logic                          rx_ready_o,
  output logic [NR_REQ-1:0]             req_rx_valid_o,
  input  logic [NR_REQ-1:0]             req_rx_ready_i,
  input  logic                          b_valid_i,
  input  logic                          b_last_i,
  input  logic                          b_error_i,
  output logic                          b_ready_o,
  output logic [NR_REQ-1:0]             req_b_valid_o,
  input  logic [NR_REQ-1:0]             req_b_ready_i,
  output logic [NR_REQ-1:0]             grant_o,
  output logic                          busy_o
);

  localparam int IDX_W = $clog2(NR_REQ);

  arb_state_t          state_r;
  logic [IDX_W-1:0]    rr_r;
  logic [IDX_W-1:0]    grant_idx_r;
  logic [NR_REQ-1:0]   grant_r;
  hyper_cmd_t          cmd_r;
  hyper_cmd_t          cmd_s;
  logic [NR_REQ-1:0]   sel_grant_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic                sel_any_s;
  logic [IDX_W-1:0]    rr_next_s;

  hyperbus_rr_select #(
    .NR_REQ (NR_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_select (
    .valid (req_trans_valid_i),
    .rr    (rr_r),
    .grant (sel_grant_s),
    .idx   (sel_idx_s),
    .any   (sel_any_s)
  );

  // Gather the selected requester's command fields for capture.
  always_comb begin
    cmd_s               = '0;
    cmd_s.address       = req_trans_address_i[32*int'(sel_idx_s) +: 32];
    cmd_s.cs            = req_trans_cs_i[NR_CS*int'(sel_idx_s) +: NR_CS];
    cmd_s.write         = req_trans_write_i[sel_idx_s];
    cmd_s.burst         = req_trans_burst_i[BURST_WIDTH*int'(sel_idx_s) +: BURST_WIDTH];
    cmd_s.burst_type    = req_trans_burst_type_i[sel_idx_s];
    cmd_s.address_space = req_trans_address_space_i[sel_idx_s];
  end

  assign rr_next_s = (grant_idx_r == IDX_W'(NR_REQ - 1)) ? '0 : grant_idx_r + IDX_W'(1);

  // Arbitration FSM: capture, issue, then own the data channel until completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ARB_IDLE;
      rr_r        <= '0;
      grant_idx_r <= '0;
      grant_r     <= '0;
      cmd_r       <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (sel_any_s) begin
            grant_r     <= sel_grant_s;
            grant_idx_r <= sel_idx_s;
            cmd_r       <= cmd_s;
            state_r     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (trans_ready_i) begin
            state_r <= cmd_r.write ? ARB_WRITE : ARB_READ;
          end
        end
        ARB_READ: begin
          if (rx_valid_i && rx_ready_o && rx_last_i) begin
            state_r <= ARB_IDLE;
            rr_r    <= rr_next_s;
            grant_r <= '0;
          end
        end
        ARB_WRITE: begin
          if (b_valid_i && b_ready_o && (b_last_i || b_error_i)) begin
            state_r <= ARB_IDLE;
            rr_r    <= rr_next_s;
            grant_r <= '0;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // Handshake steering; anything outside the owner's data state stays closed.
  always_comb begin
    req_trans_ready_o = '0;
    rx_ready_o        = 1'b0;
    req_rx_valid_o    = '0;
    tx_valid_o        = 1'b0;
    req_tx_ready_o    = '0;
    tx_data_o         = 16'h0000;
    tx_strb_o         = 2'b00;
    b_ready_o         = 1'b0;
    req_b_valid_o     = '0;
    case (state_r)
      ARB_IDLE: begin
        req_trans_ready_o = sel_grant_s;
      end
      ARB_READ: begin
        rx_ready_o     = |(req_rx_ready_i & grant_r);
        req_rx_valid_o = grant_r & {NR_REQ{rx_valid_i}};
      end
      ARB_WRITE: begin
        tx_valid_o     = |(req_tx_valid_i & grant_r);
        req_tx_ready_o = grant_r & {NR_REQ{tx_ready_i}};
        tx_data_o      = req_tx_data_i[16*int'(grant_idx_r) +: 16];
        tx_strb_o      = req_tx_strb_i[2*int'(grant_idx_r) +: 2];
        b_ready_o      = |(req_b_ready_i & grant_r);
        req_b_valid_o  = grant_r & {NR_REQ{b_valid_i}};
      end
      default: begin
        req_trans_ready_o = '0;
      end
    endcase
  end

  assign trans_valid_o         = (state_r == ARB_ISSUE);
  assign trans_address_o       = cmd_r.address;
  assign trans_cs_o            = cmd_r.cs;
  assign trans_write_o         = cmd_r.write;
  assign trans_burst_o         = cmd_r.burst;
  assign trans_burst_type_o    = cmd_r.burst_type;
  assign trans_address_space_o = cmd_r.address_space;
  assign grant_o               = grant_r;
  assign busy_o                = (state_r != ARB_IDLE);

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Randomized bench for hyperbus_trans_arbiter with three requesters, checked
// against a round-robin ownership model kept in the bench.
module tb_hyperbus_trans_arbiter;

  localparam int N   = 3;
  localparam int CSW = 2;
  localparam int BW  = 12;

  logic              clk, rst_n;
  logic [N-1:0]      req_trans_valid, req_trans_ready;
  logic [N*32-1:0]   req_trans_address;
  logic [N*CSW-1:0]  req_trans_cs;
  logic [N-1:0]      req_trans_write;
  logic [N*BW-1:0]   req_trans_burst;
  logic [N-1:0]      req_trans_burst_type, req_trans_address_space;
  logic              trans_valid, trans_ready;
  logic [31:0]       trans_address;
  logic [CSW-1:0]    trans_cs;
  logic              trans_write, trans_burst_type, trans_address_space;
  logic [BW-1:0]     trans_burst;
  logic [N-1:0]      req_tx_valid, req_tx_ready;
  logic [N*16-1:0]   req_tx_data;
  logic [N*2-1:0]    req_tx_strb;
  logic              tx_valid, tx_ready;
  logic [15:0]       tx_data;
  logic [1:0]        tx_strb;
  logic              rx_valid, rx_last, rx_ready;
  logic [N-1:0]      req_rx_valid, req_rx_ready;
  logic              b_valid, b_last, b_error, b_ready;
  logic [N-1:0]      req_b_valid, req_b_ready;
  logic [N-1:0]      grant;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  int mdl_rr = 0;
  logic [31:0]       cap_addr;
  logic [CSW+BW+2:0] cap_rest;
  logic              cap_write;

  hyperbus_trans_arbiter #(.NR_REQ(N), .NR_CS(CSW), .BURST_WIDTH(BW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_trans_valid_i(req_trans_valid), .req_trans_ready_o(req_trans_ready),
    .req_trans_address_i(req_trans_address), .req_trans_cs_i(req_trans_cs),
    .req_trans_write_i(req_trans_write), .req_trans_burst_i(req_trans_burst),
    .req_trans_burst_type_i(req_trans_burst_type),
    .req_trans_address_space_i(req_trans_address_space),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready),
    .trans_address_o(trans_address), .trans_cs_o(trans_cs),
    .trans_write_o(trans_write), .trans_burst_o(trans_burst),
    .trans_burst_type_o(trans_burst_type), .trans_address_space_o(trans_address_space),
    .req_tx_valid_i(req_tx_valid), .req_tx_ready_o(req_tx_ready),
    .req_tx_data_i(req_tx_data), .req_tx_strb_i(req_tx_strb),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data), .tx_strb_o(tx_strb),
    .rx_valid_i(rx_valid), .rx_last_i(rx_last), .rx_ready_o(rx_ready),
    .req_rx_valid_o(req_rx_valid), .req_rx_ready_i(req_rx_ready),
    .b_valid_i(b_valid), .b_last_i(b_last), .b_error_i(b_error), .b_ready_o(b_ready),
    .req_b_valid_o(req_b_valid), .req_b_ready_i(req_b_ready),
    .grant_o(grant), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Round-robin reference: first valid requester scanning from the pointer.
  function automatic int mdl_pick(input logic [N-1:0] mask, input int rr);
    for (int k = 0; k < N; k++) begin
      if (mask[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic clear_data();
    trans_ready = 1'b0;
    rx_valid = 1'b0; rx_last = 1'b0; req_rx_ready = '0;
    b_valid = 1'b0; b_last = 1'b0; b_error = 1'b0; req_b_ready = '0;
    req_tx_valid = '0; req_tx_data = '0; req_tx_strb = '0; tx_ready = 1'b0;
  endtask

  task automatic rand_fields(input int i);
    req_trans_address[32*i +: 32]  = $urandom;
    req_trans_cs[CSW*i +: CSW]     = CSW'($urandom);
    req_trans_write[i]             = 1'($urandom);
    req_trans_burst[BW*i +: BW]    = BW'($urandom);
    req_trans_burst_type[i]        = 1'($urandom);
    req_trans_address_space[i]     = 1'($urandom);
  endtask

  task automatic arbitrate(input logic [N-1:0] mask, output int w);
    req_trans_valid = mask;
    #1;
    w = mdl_pick(mask, mdl_rr);
    vectors++;
    if (req_trans_ready !== onehot(w)) begin
      miscompares++;
      $display("FAIL arb_ready: got %b want %b", req_trans_ready, onehot(w));
    end
    cap_addr  = req_trans_address[32*w +: 32];
    cap_write = req_trans_write[w];
    cap_rest  = {req_trans_cs[CSW*w +: CSW], req_trans_write[w], req_trans_burst[BW*w +: BW],
                 req_trans_burst_type[w], req_trans_address_space[w]};
    cyc();
    req_trans_valid[w] = 1'b0;
    #1;
    vectors++;
    if (grant !== onehot(w) || busy !== 1'b1 || trans_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arb_grant: got grant=%b busy=%b tv=%b want grant=%b busy=1 tv=1",
               grant, busy, trans_valid, onehot(w));
    end
  endtask

  task automatic issue(input int w, input int stall, input bit scramble);
    for (int s = 0; s <= stall; s++) begin
      trans_ready = (s == stall);
      if (scramble) begin
        req_trans_address[32*w +: 32] = $urandom;
        req_trans_burst[BW*w +: BW]   = BW'($urandom);
        req_trans_write[w]            = ~req_trans_write[w];
      end
      #1;
      vectors++;
      if (trans_valid !== 1'b1 || trans_address !== cap_addr ||
          {trans_cs, trans_write, trans_burst, trans_burst_type, trans_address_space} !== cap_rest) begin
        miscompares++;
        $display("FAIL issue_cmd: got tv=%b addr=%h rest=%h want tv=1 addr=%h rest=%h",
                 trans_valid, trans_address,
                 {trans_cs, trans_write, trans_burst, trans_burst_type, trans_address_space},
                 cap_addr, cap_rest);
      end
      vectors++;
      if (req_trans_ready !== '0 || grant !== onehot(w)) begin
        miscompares++;
        $display("FAIL issue_hold: got ready=%b grant=%b want ready=0 grant=%b",
                 req_trans_ready, grant, onehot(w));
      end
      cyc();
    end
    trans_ready = 1'b0;
  endtask

  // Data phase with random backpressure and stray beats on the other channel.
  task automatic serve(input int w, input bit wr, input int beats, input bit err_end);
    int sent;
    bit done;
    bit bphase;
    logic [N-1:0] oh;
    oh = onehot(w);
    sent = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (!wr) begin
        rx_valid = ($urandom_range(0, 3) != 0);
        rx_last = (sent == beats - 1);
        req_rx_ready = N'($urandom);
        b_valid = 1'($urandom); b_last = 1'b1; b_error = 1'b0; req_b_ready = '1;
        req_tx_valid = '1; tx_ready = 1'b1;
        #1;
        vectors++;
        if (rx_ready !== req_rx_ready[w] || req_rx_valid !== (rx_valid ? oh : '0)) begin
          miscompares++;
          $display("FAIL read_route: got rdy=%b vld=%b want rdy=%b vld=%b",
                   rx_ready, req_rx_valid, req_rx_ready[w], (rx_valid ? oh : '0));
        end
        vectors++;
        if (b_ready !== 1'b0 || req_b_valid !== '0 || tx_valid !== 1'b0 || req_tx_ready !== '0) begin
          miscompares++;
          $display("FAIL read_isolate: got b_rdy=%b b_vld=%b tx_vld=%b tx_rdy=%b want all 0",
                   b_ready, req_b_valid, tx_valid, req_tx_ready);
        end
        if (rx_valid && req_rx_ready[w]) begin
          sent++;
          if (rx_last) done = 1'b1;
        end
      end else begin
        bphase = (sent >= beats);
        req_tx_valid = N'($urandom); req_tx_data = {$urandom, $urandom};
        req_tx_strb = N*2'($urandom); tx_ready = 1'($urandom);
        b_valid = bphase ? 1'($urandom) : 1'b0;
        b_last = ~err_end; b_error = err_end; req_b_ready = N'($urandom);
        rx_valid = 1'($urandom); rx_last = 1'b1; req_rx_ready = '1;
        #1;
        vectors++;
        if (tx_valid !== req_tx_valid[w] || req_tx_ready !== (tx_ready ? oh : '0) ||
            tx_data !== req_tx_data[16*w +: 16] || tx_strb !== req_tx_strb[2*w +: 2]) begin
          miscompares++;
          $display("FAIL write_tx: got v=%b r=%b d=%h s=%b want v=%b r=%b d=%h s=%b",
                   tx_valid, req_tx_ready, tx_data, tx_strb, req_tx_valid[w],
                   (tx_ready ? oh : '0), req_tx_data[16*w +: 16], req_tx_strb[2*w +: 2]);
        end
        vectors++;
        if (b_ready !== req_b_ready[w] || req_b_valid !== (b_valid ? oh : '0)) begin
          miscompares++;
          $display("FAIL write_b: got rdy=%b vld=%b want rdy=%b vld=%b",
                   b_ready, req_b_valid, req_b_ready[w], (b_valid ? oh : '0));
        end
        vectors++;
        if (rx_ready !== 1'b0 || req_rx_valid !== '0) begin
          miscompares++;
          $display("FAIL write_isolate: got rx_rdy=%b rx_vld=%b want 0", rx_ready, req_rx_valid);
        end
        if (!bphase && req_tx_valid[w] && tx_ready) sent++;
        if (b_valid && req_b_ready[w]) done = 1'b1;
      end
      cyc();
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL serve_timeout: got no completion want completion within 300 cycles");
    end
    clear_data();
    #1;
    vectors++;
    if (busy !== 1'b0 || grant !== '0) begin
      miscompares++;
      $display("FAIL serve_release: got busy=%b grant=%b want busy=0 grant=0", busy, grant);
    end
    mdl_rr = (w + 1) % N;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_trans_valid = '0; req_trans_address = '0; req_trans_cs = '0; req_trans_write = '0;
    req_trans_burst = '0; req_trans_burst_type = '0; req_trans_address_space = '0;
    clear_data();
    repeat (3) cyc();
    vectors++;
    if (busy !== 1'b0 || grant !== '0 || trans_valid !== 1'b0 || trans_address !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b grant=%b tv=%b addr=%h want 0", busy, grant,
               trans_valid, trans_address);
    end
    vectors++;
    if (rx_ready !== 1'b0 || b_ready !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 16'h0 ||
        req_trans_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rx=%b b=%b tx=%b d=%h rdy=%b want 0", rx_ready, b_ready,
               tx_valid, tx_data, req_trans_ready);
    end
    rst_n = 1'b1;
    mdl_rr = 0;
    cyc();
  endtask

  task automatic test_simultaneous();
    int w;
    rand_fields(0); rand_fields(1);
    req_trans_write[0] = 1'b1;
    req_trans_write[1] = 1'b0;
    arbitrate(3'b011, w);
    issue(w, 0, 1'b0);
    serve(w, cap_write, 2, 1'b0);
    arbitrate(3'b010, w);
    issue(w, 1, 1'b0);
    serve(w, cap_write, 3, 1'b0);
  endtask

  task automatic test_rr_three();
    int w;
    rand_fields(0); rand_fields(2);
    arbitrate(3'b101, w);
    issue(w, 0, 1'b0);
    serve(w, cap_write, 2, 1'b0);
    arbitrate(3'b001, w);
    issue(w, 0, 1'b0);
    serve(w, cap_write, 1, 1'b0);
  endtask

  task automatic test_single_read();
    int w;
    rand_fields(0);
    req_trans_write[0] = 1'b0;
    req_trans_address[31:0] = 32'h0000_0100;
    req_trans_burst[BW-1:0] = BW'(4);
    arbitrate(3'b001, w);
    vectors++;
    if (trans_burst !== BW'(4) || trans_address !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL read_cmd: got burst=%0d addr=%h want burst=4 addr=00000100",
               trans_burst, trans_address);
    end
    issue(w, 0, 1'b0);
    serve(w, 1'b0, 4, 1'b0);
  endtask

  task automatic test_b_error();
    int w;
    rand_fields(1);
    req_trans_write[1] = 1'b1;
    arbitrate(3'b010, w);
    issue(w, 2, 1'b0);
    serve(w, 1'b1, 1, 1'b1);
  endtask

  task automatic test_issue_stall();
    int w;
    rand_fields(0);
    arbitrate(3'b001, w);
    issue(w, 5, 1'b1);
    serve(w, cap_write, 2, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    int w;
    for (int i = 0; i < N; i++) begin
      rand_fields(i);
      req_trans_write[i] = 1'b0;
    end
    arbitrate(3'b111, w);
    issue(w, 0, 1'b0);
    req_trans_valid = '0;
    rx_valid = 1'b1; rx_last = 1'b0; req_rx_ready = '1;
    #1;
    vectors++;
    if (rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_read: got rx_ready=%b want 1", rx_ready);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rx_ready !== 1'b0 || grant !== '0 || req_rx_valid !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_read: got rdy=%b grant=%b vld=%b busy=%b want 0",
               rx_ready, grant, req_rx_valid, busy);
    end
    cyc();
    rst_n = 1'b1;
    clear_data();
    mdl_rr = 0;
    cyc();
    vectors++;
    if (busy !== 1'b0 || trans_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got busy=%b tv=%b want 0", busy, trans_valid);
    end
    arbitrate(3'b111, w);
    issue(w, 0, 1'b0);
    serve(w, cap_write, 1, 1'b0);
  endtask

  task automatic test_random();
    int w;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) rand_fields(i);
      arbitrate(N'($urandom_range(1, 7)), w);
      issue(w, $urandom_range(0, 3), 1'b0);
      serve(w, cap_write, $urandom_range(1, 4), 1'($urandom));
      req_trans_valid = '0;
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_rr_three();
    test_single_read();
    test_b_error();
    test_issue_stall();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hyperbus_trans_arbiter.md
Name: hyperbus_trans_arbiter

Overview:
- Shares the single HyperBus PHY transaction channel between NR_REQ requesters, e.g. the AXI frontend and a register/config-access frontend.
- Picks one requester round-robin and registers its command.
- Issues the command to the PHY, then routes the tx, rx and b handshakes to that requester only.
- Holds the grant until the transaction's final beat or response has been consumed.

Parameters:
- NR_REQ, 2, number of requesters (>=2).
- NR_CS, 2, chip-select width.
- BURST_WIDTH, 12, burst length field width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_trans_valid_i  in  NR_REQ  per-requester command valid
- req_trans_ready_o  out  NR_REQ  per-requester command accepted
- req_trans_address_i  in  NR_REQ*32  command address, requester i at [32*i+:32]
- req_trans_cs_i  in  NR_REQ*NR_CS  command chip selects
- req_trans_write_i  in  NR_REQ  command is a write
- req_trans_burst_i  in  NR_REQ*BURST_WIDTH  burst length
- req_trans_burst_type_i  in  NR_REQ  burst type
- req_trans_address_space_i  in  NR_REQ  register/memory space select
- trans_valid_o  out  1  command to PHY
- trans_ready_i  in  1  PHY accepts command
- trans_address_o  out  32
- trans_cs_o  out  NR_CS
- trans_write_o  out  1
- trans_burst_o  out  BURST_WIDTH
- trans_burst_type_o  out  1
- trans_address_space_o  out  1
- req_tx_valid_i  in  NR_REQ  write data valid
- req_tx_ready_o  out  NR_REQ  write data ready
- req_tx_data_i  in  NR_REQ*16  write data
- req_tx_strb_i  in  NR_REQ*2  write strobes
- tx_valid_o  out  1  write data to PHY
- tx_ready_i  in  1
- tx_data_o  out  16
- tx_strb_o  out  2
- rx_valid_i  in  1  read beat from PHY; rx data, last and error are broadcast to all requesters outside this block
- rx_last_i  in  1
- rx_ready_o  out  1
- req_rx_valid_o  out  NR_REQ
- req_rx_ready_i  in  NR_REQ
- b_valid_i  in  1  write response from PHY
- b_last_i  in  1
- b_error_i  in  1
- b_ready_o  out  1
- req_b_valid_o  out  NR_REQ
- req_b_ready_i  in  NR_REQ
- grant_o  out  NR_REQ  one-hot current owner; all zeros when idle
- busy_o  out  1  state is not ARB_IDLE

Behaviour:
- States: ARB_IDLE, ARB_ISSUE, ARB_READ, ARB_WRITE.
- Reset value: state ARB_IDLE, rr_q=0, grant=0, all command registers 0, every output 0.
- Reset mid-operation: state returns to ARB_IDLE; the in-flight PHY transaction is abandoned, and the PHY is reset by the same rst_ni.
- ARB_IDLE:
  - Select g = first i with req_trans_valid_i[i], scanning rr_q, rr_q+1, ... modulo NR_REQ.
  - If any requester is valid: drive req_trans_ready_o[g]=1 combinationally, register g and all of g's command fields, go to ARB_ISSUE.
  - Latency: requester valid at cycle N -> trans_valid_o=1 at N+1.
- ARB_ISSUE:
  - trans_valid_o=1; trans_* come from the registers and stay stable while trans_ready_i=0.
  - On trans_ready_i=1: go to ARB_READ if the registered write bit is 0, else ARB_WRITE.
- ARB_READ:
  - rx_ready_o = req_rx_ready_i[g]; req_rx_valid_o[g] = rx_valid_i; all other bits 0.
  - On rx_valid_i && rx_ready_o && rx_last_i: go to ARB_IDLE, rr_q <= (g+1) mod NR_REQ, grant cleared.
- ARB_WRITE:
  - tx_valid_o = req_tx_valid_i[g]; req_tx_ready_o[g] = tx_ready_i; tx_data_o and tx_strb_o muxed from g.
  - b_ready_o = req_b_ready_i[g]; req_b_valid_o[g] = b_valid_i.
  - On b_valid_i && b_ready_o && (b_last_i || b_error_i): go to ARB_IDLE, rr_q advances as in ARB_READ.
- Outside the matching data state: rx_ready_o, b_ready_o and tx_valid_o are 0, all req_* valid/ready outputs are 0, and tx_data_o/tx_strb_o are 0. Stray PHY beats are therefore held by the PHY, never dropped.
- A requester must hold its command fields stable while req_trans_valid_i is high. Dropping valid without a handshake is legal only in ARB_IDLE.
- Only one transaction is outstanding at a time; no pipelining of a second command.

Decomposition:
- Package hyperbus_arb_pkg:
  - arb_state_t enum (ARB_IDLE, ARB_ISSUE, ARB_READ, ARB_WRITE).
  - hyper_cmd_t packed struct (address, cs, write, burst, burst_type, address_space), parameterised by the package localparams HYPER_NR_CS and HYPER_BURST_W.
- Sub-module hyperbus_rr_select:
  - Combinational rotate-priority-encode.
  - Inputs: valid vector and rr pointer. Outputs: one-hot grant and index.

Test Plan:
- Req0 read, burst 4, addr 0x100, valid at cycle 10 -> req_trans_ready_o[0] at 10; trans_valid_o at 11 with trans_burst_o=4. Four rx beats go only to req_rx_valid_o[0]; busy_o=0 the cycle after the last beat.
- Req0 and req1 valid together at rr_q=0, req0 write with 2 beats, req1 read -> req0 is served first, tx beats reach tx_data_o, b_last completes it; then req1 issues; rr_q=0 afterwards.
- Write with b_valid_i=1, b_error_i=1, b_last_i=0 -> req_b_valid_o[g]=1; returns to ARB_IDLE on handshake.
- trans_ready_i held low for 5 cycles in ARB_ISSUE while req0 changes its inputs -> trans_valid_o stays 1 and trans_address_o keeps the captured value.
- NR_REQ=3, rr_q=2, req0 and req2 valid -> grant_o=3'b100 first, then 3'b001.
- rst_ni asserted in ARB_READ with rx_valid_i=1 -> rx_ready_o=0 and grant_o=0 immediately; state is ARB_IDLE after release.
